dircc_mailbox_poller: RTL and testbench

DIRCC_MAILBOX_POLLER -- requirements
Module: dircc_mailbox_poller

---
 rtl/dircc_mailbox_poller.sv | 216 +++++++++++++++++++++
 tb/tb_dircc_mailbox_poller.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dircc_mailbox_poller.sv
// -----------------------------------------------------------------------------
// dircc_mailbox_poller
//
// Round-robin poller that drains the four directional mailboxes (north, east,
// south, west) of a DIRCC node into a receive ring held in node memory.
//
// For each direction the poller reads the status word (address 0). If a
// message is pending and the ring has room for two words, it reads the two
// payload words (addresses 1 and 2), writes each into the ring, and then reads
// address 3, which pops the mailbox. A direction with nothing pending, or one
// whose message does not fit, costs a single status read.
//
// Ports
//   clk_clk             in   single rising-edge clock
//   reset_reset         in   asynchronous active-high reset
//   enable              in   polling permitted while high
//   dir_mem_address     out  mailbox word address, 2 bits per direction
//   dir_mem_read_n      out  active-low read strobe, 1 bit per direction
//   dir_mem_readdata    in   mailbox data, 16 bits per direction, valid the
//                            cycle after the strobe
//   node_mem_address    out  ring write address (BASE_ADDR + write pointer)
//   node_mem_writedata  out  ring write data
//   node_mem_write      out  ring write request, held until accepted
//   node_mem_waitrequest in  ring write stalled while high
//   consume             in   pulse: processor removed one 2-word message
//   ring_count          out  words currently held in the ring
//   irq                 out  high while at least one full message is held
//   msg_count           out  popped-message counter, saturating (only when
//                            DIRCC_POLLER_STATS_EN is defined)
//
// Build option
//   DIRCC_POLLER_STATS_EN  adds the msg_count output and its counter.
// -----------------------------------------------------------------------------
module dircc_mailbox_poller #(
  parameter logic [14:0] BASE_ADDR  = 15'h0100,
  parameter int unsigned RING_WORDS = 16
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        enable,
  output logic [7:0]                  dir_mem_address,
  output logic [3:0]                  dir_mem_read_n,
  input  logic [63:0]                 dir_mem_readdata,
  output logic [14:0]                 node_mem_address,
  output logic [15:0]                 node_mem_writedata,
  output logic                        node_mem_write,
  input  logic                        node_mem_waitrequest,
  input  logic                        consume,
  output logic [$clog2(RING_WORDS):0] ring_count,
  output logic                        irq
`ifdef DIRCC_POLLER_STATS_EN
  ,
  output logic [15:0]                 msg_count
`endif
);

  localparam int unsigned PtrW = $clog2(RING_WORDS);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] RingWordsC = CntW'(RING_WORDS);
  localparam logic [CntW-1:0] MsgWordsC  = CntW'(2);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StWr} state_e;

  state_e          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      idx_q, idx_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     data_q, data_d;

  logic [15:0]     cap_word;
  logic            has_room;
  logic            wr_accept;
  logic            consume_ok;
  logic            pop;

  // Word returned by the mailbox currently being polled.
  assign cap_word = dir_mem_readdata[{dir_q, 4'b0000} +: 16];

  // Room is checked once, at the status read; the poller is the only writer,
  // so the space cannot shrink before both payload words are written.
  assign has_room = (RingWordsC - count_q) >= MsgWordsC;

  // A consume with less than one whole message in the ring is ignored.
  assign consume_ok = consume && (count_q >= MsgWordsC);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q  <= StIdle;
      dir_q    <= 2'd0;
      idx_q    <= 2'd0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and mailbox / ring strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    dir_d           = dir_q;
    idx_d           = idx_q;
    wr_ptr_d        = wr_ptr_q;
    data_d          = data_q;
    wr_accept       = 1'b0;
    pop             = 1'b0;
    dir_mem_read_n  = 4'hF;
    dir_mem_address = 8'h00;
    node_mem_write  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRd;
          idx_d   = 2'd0;
        end
      end

      StRd: begin
        dir_mem_read_n[dir_q]              = 1'b0;
        dir_mem_address[{dir_q, 1'b0} +: 2] = idx_q;
        state_d                            = StCap;
      end

      StCap: begin
        unique case (idx_q)
          2'd0: begin
            if (cap_word[0] && has_room) begin
              idx_d   = 2'd1;
              state_d = StRd;
            end else begin
              state_d = StIdle;
              dir_d   = dir_q + 2'd1;
            end
          end
          2'd1, 2'd2: begin
            data_d  = cap_word;
            state_d = StWr;
          end
          2'd3: begin
            // The address-3 read has already popped the mailbox; its data is
            // of no interest.
            pop     = 1'b1;
            state_d = StIdle;
            dir_d   = dir_q + 2'd1;
          end
          default: state_d = StIdle;
        endcase
      end

      StWr: begin
        node_mem_write = 1'b1;
        if (!node_mem_waitrequest) begin
          wr_accept = 1'b1;
          wr_ptr_d  = wr_ptr_q + PtrW'(1);
          idx_d     = idx_q + 2'd1;
          state_d   = StRd;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Ring occupancy: +1 per accepted write, -2 per honoured consume, netted.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    if (wr_accept) begin
      count_d = count_d + CntW'(1);
    end
    if (consume_ok) begin
      count_d = count_d - MsgWordsC;
    end
  end

  assign node_mem_address   = BASE_ADDR + 15'(wr_ptr_q);
  assign node_mem_writedata = data_q;
  assign ring_count         = count_q;
  assign irq                = count_q >= MsgWordsC;

`ifdef DIRCC_POLLER_STATS_EN
  // ---------------------------------------------------------------------------
  // Popped-message counter, saturating.
  // ---------------------------------------------------------------------------
  logic [15:0] msg_count_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      msg_count_q <= 16'h0000;
    end else if (pop && (msg_count_q != 16'hFFFF)) begin
      msg_count_q <= msg_count_q + 16'd1;
    end
  end

  assign msg_count = msg_count_q;
`else
  // Pop is only observed by the statistics counter.
  logic unused_pop;
  assign unused_pop = pop;
`endif

endmodule

// File: tb/tb_dircc_mailbox_poller.sv
// -----------------------------------------------------------------------------
// tb_dircc_mailbox_poller
//
// Directed and randomized checks of dircc_mailbox_poller (default parameters:
// ring at 15'h0100, 16 words). Mailboxes and node memory are modelled inside
// the bench; expected ring contents come from the messages loaded, in
// round-robin direction order, written at consecutive ring addresses.
// -----------------------------------------------------------------------------
module tb_dircc_mailbox_poller;

  logic        clk_clk              = 1'b0;
  logic        reset_reset          = 1'b0;
  logic        enable               = 1'b0;
  logic        consume              = 1'b0;
  logic        node_mem_waitrequest = 1'b0;
  logic [63:0] dir_mem_readdata     = '0;
  logic [7:0]  dir_mem_address;
  logic [3:0]  dir_mem_read_n;
  logic [14:0] node_mem_address;
  logic [15:0] node_mem_writedata;
  logic        node_mem_write;
  logic [4:0]  ring_count;
  logic        irq;
`ifdef DIRCC_POLLER_STATS_EN
  logic [15:0] msg_count;
`endif

  dircc_mailbox_poller dut (
    .clk_clk              (clk_clk),
    .reset_reset          (reset_reset),
    .enable               (enable),
    .dir_mem_address      (dir_mem_address),
    .dir_mem_read_n       (dir_mem_read_n),
    .dir_mem_readdata     (dir_mem_readdata),
    .node_mem_address     (node_mem_address),
    .node_mem_writedata   (node_mem_writedata),
    .node_mem_write       (node_mem_write),
    .node_mem_waitrequest (node_mem_waitrequest),
    .consume              (consume),
    .ring_count           (ring_count),
    .irq                  (irq)
`ifdef DIRCC_POLLER_STATS_EN
    ,
    .msg_count            (msg_count)
`endif
  );

  initial forever #5 clk_clk = ~clk_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Mailbox model: a direction holds a message while loads outnumber pops.
  int          load_cnt [4] = '{0, 0, 0, 0};
  int          pop_cnt  [4] = '{0, 0, 0, 0};
  logic [15:0] mb_w0    [4];
  logic [15:0] mb_w1    [4];

  // Ring model: log of accepted writes and expected occupancy.
  logic [14:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int          wr_base = 0;
  int          m_count = 0;

  // Strobe log.
  logic [3:0]  strobe_val [$];
  logic [1:0]  strobe_adr [$];
  int          strobe_cyc [$];
  int          st_cyc [4];
  int          cyc = 0;

  logic        p_rst, p_write, p_wait;
  logic [14:0] p_addr;
  logic [15:0] p_data;

  logic [15:0] exp_w [$];
  int          n, hold, pops0;
  logic [3:0]  mask;

  function automatic bit mb_pending(input int d);
    return load_cnt[d] != pop_cnt[d];
  endfunction

  function automatic int total_pops();
    return pop_cnt[0] + pop_cnt[1] + pop_cnt[2] + pop_cnt[3];
  endfunction

  function automatic bit any_pending();
    return mb_pending(0) || mb_pending(1) || mb_pending(2) || mb_pending(3);
  endfunction

  function automatic int n_writes();
    return wr_addr_q.size() - wr_base;
  endfunction

  // Mailbox responder: data appears the cycle after the strobe; address 3 pops.
  always @(posedge clk_clk) begin
    for (int d = 0; d < 4; d++) begin
      if (dir_mem_read_n[d] == 1'b0) begin
        case (dir_mem_address[2*d +: 2])
          2'd0:    dir_mem_readdata[16*d +: 16] <= {15'h0000, mb_pending(d)};
          2'd1:    dir_mem_readdata[16*d +: 16] <= mb_w0[d];
          2'd2:    dir_mem_readdata[16*d +: 16] <= mb_w1[d];
          default: begin
            dir_mem_readdata[16*d +: 16] <= 16'hDEAD;
            pop_cnt[d] <= pop_cnt[d] + 1;
          end
        endcase
      end
    end
  end

  // Node memory and occupancy model.
  always @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      m_count <= 0;
    end else begin
      if (node_mem_write && !node_mem_waitrequest) begin
        wr_addr_q.push_back(node_mem_address);
        wr_data_q.push_back(node_mem_writedata);
      end
      m_count <= m_count + ((node_mem_write && !node_mem_waitrequest) ? 1 : 0)
                 - ((consume && m_count >= 2) ? 2 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; samples 1 ns after the edge and checks per-cycle invariants.
  task automatic tick();
    p_rst   = reset_reset;
    p_write = node_mem_write;
    p_wait  = node_mem_waitrequest;
    p_addr  = node_mem_address;
    p_data  = node_mem_writedata;
    @(posedge clk_clk);
    #1;
    cyc++;
    chk("ring_count", 32'(ring_count), 32'(m_count));
    chk("irq", 32'(irq), (m_count >= 2) ? 32'd1 : 32'd0);
    chk("one_strobe", ($countones(~dir_mem_read_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (!reset_reset && !p_rst && p_write && p_wait) begin
      chk("hold_write", 32'(node_mem_write), 32'd1);
      chk("hold_addr", 32'(node_mem_address), 32'(p_addr));
      chk("hold_data", 32'(node_mem_writedata), 32'(p_data));
    end
    for (int d = 0; d < 4; d++) begin
      if (dir_mem_read_n[d] == 1'b0) begin
        strobe_val.push_back(dir_mem_read_n);
        strobe_adr.push_back(dir_mem_address[2*d +: 2]);
        strobe_cyc.push_back(cyc);
        if (dir_mem_address[2*d +: 2] == 2'd0 && st_cyc[d] < 0) st_cyc[d] = cyc;
      end
    end
  endtask

  task automatic clear_logs();
    strobe_val.delete();
    strobe_adr.delete();
    strobe_cyc.delete();
    for (int d = 0; d < 4; d++) st_cyc[d] = -1;
    wr_base = wr_addr_q.size();
  endtask

  task automatic do_reset();
    enable               = 1'b0;
    consume              = 1'b0;
    node_mem_waitrequest = 1'b0;
    reset_reset          = 1'b1;
    tick();
    tick();
    reset_reset = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic load(input int d, input logic [15:0] w0, input logic [15:0] w1);
    mb_w0[d] = w0;
    mb_w1[d] = w1;
    load_cnt[d]++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read_n"}, 32'(dir_mem_read_n), 32'hF);
    chk({tag, "_dir_addr"}, 32'(dir_mem_address), 32'h0);
    chk({tag, "_write"}, 32'(node_mem_write), 32'h0);
    chk({tag, "_node_addr"}, 32'(node_mem_address), 32'h0100);
    chk({tag, "_wdata"}, 32'(node_mem_writedata), 32'h0);
    chk({tag, "_count"}, 32'(ring_count), 32'h0);
    chk({tag, "_irq"}, 32'(irq), 32'h0);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) st_cyc[d] = -1;

    // Asynchronous reset, before any clock edge.
    #2 reset_reset = 1'b1;
    #1;
    chk_reset_outputs("rst");
    do_reset();

    // All mailboxes empty: one status read per direction, 3 cycles apart.
    enable = 1'b1;
    repeat (14) tick();
    chk("empty_nstrobes", (strobe_val.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (strobe_val.size() >= 4) begin
      chk("empty_strobe0", 32'(strobe_val[0]), 32'hE);
      chk("empty_strobe1", 32'(strobe_val[1]), 32'hD);
      chk("empty_strobe2", 32'(strobe_val[2]), 32'hB);
      chk("empty_strobe3", 32'(strobe_val[3]), 32'h7);
      for (int i = 0; i < 4; i++) chk("empty_status_addr", 32'(strobe_adr[i]), 32'h0);
      for (int i = 0; i < 3; i++) chk("empty_spacing", 32'(strobe_cyc[i+1] - strobe_cyc[i]), 32'd3);
    end
    chk("empty_no_writes", 32'(n_writes()), 32'd0);

    // One east message, no stalls: 11 cycles, two ring writes, then a pop.
    do_reset();
    pops0 = total_pops();
    load(1, 16'hA5A5, 16'h5A5A);
    enable = 1'b1;
    repeat (20) tick();
    chk("east_gap_n_e", 32'(st_cyc[1] - st_cyc[0]), 32'd3);
    chk("east_gap_e_s", 32'(st_cyc[2] - st_cyc[1]), 32'd11);
    chk("east_nwr", 32'(n_writes()), 32'd2);
    if (n_writes() == 2) begin
      chk("east_addr0", 32'(wr_addr_q[wr_base]), 32'h0100);
      chk("east_data0", 32'(wr_data_q[wr_base]), 32'hA5A5);
      chk("east_addr1", 32'(wr_addr_q[wr_base+1]), 32'h0101);
      chk("east_data1", 32'(wr_data_q[wr_base+1]), 32'h5A5A);
    end
    chk("east_popped", 32'(mb_pending(1)), 32'd0);
    chk("east_pops", 32'(total_pops() - pops0), 32'd1);
    chk("east_count", 32'(ring_count), 32'd2);
    chk("east_irq", 32'(irq), 32'd1);

    // Enable dropped mid-message: the direction completes, then polling stops.
    do_reset();
    load(0, 16'h0C0C, 16'h0D0D);
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    repeat (20) tick();
    chk("disable_nwr", 32'(n_writes()), 32'd2);
    chk("disable_popped", 32'(mb_pending(0)), 32'd0);
    clear_logs();
    repeat (6) tick();
    chk("disable_idle", 32'(strobe_val.size()), 32'd0);

    // First write stalled 5 cycles: request held 6 cycles, accepted once.
    do_reset();
    node_mem_waitrequest = 1'b1;
    load(0, 16'h1111, 16'h2222);
    enable = 1'b1;
    n = 0;
    while (!node_mem_write && n < 40) begin
      tick();
      n++;
    end
    chk("stall_write_seen", 32'(node_mem_write), 32'd1);
    hold = 0;
    for (int c = 1; c <= 12 && node_mem_write; c++) begin
      hold++;
      chk("stall_addr", 32'(node_mem_address), 32'h0100);
      chk("stall_data", 32'(node_mem_writedata), 32'h1111);
      node_mem_waitrequest = (c < 6);
      tick();
    end
    node_mem_waitrequest = 1'b0;
    chk("stall_hold_cycles", 32'(hold), 32'd6);
    chk("stall_single_accept", 32'(n_writes()), 32'd1);
    repeat (12) tick();
    chk("stall_nwr", 32'(n_writes()), 32'd2);
    if (n_writes() == 2) begin
      chk("stall_addr1", 32'(wr_addr_q[wr_base+1]), 32'h0101);
      chk("stall_data1", 32'(wr_data_q[wr_base+1]), 32'h2222);
    end

    // Fill the ring, then a pending message must wait for a consume.
    do_reset();
    for (int d = 0; d < 4; d++) load(d, 16'h1000 + 16'(d), 16'h2000 + 16'(d));
    enable = 1'b1;
    repeat (50) tick();
    for (int d = 0; d < 4; d++) load(d, 16'h3000 + 16'(d), 16'h4000 + 16'(d));
    repeat (70) tick();
    chk("full_count", 32'(ring_count), 32'd16);
    chk("full_nwr", 32'(n_writes()), 32'd16);
    if (n_writes() == 16) begin
      for (int i = 0; i < 16; i++) chk("full_addr", 32'(wr_addr_q[wr_base+i]), 32'h0100 + i);
      for (int d = 0; d < 4; d++) begin
        chk("full_data_w0", 32'(wr_data_q[wr_base+2*d]), 32'h1000 + d);
        chk("full_data_w1", 32'(wr_data_q[wr_base+2*d+1]), 32'h2000 + d);
      end
    end
    load(0, 16'hBEEF, 16'hCAFE);
    for (int d = 0; d < 4; d++) st_cyc[d] = -1;
    pops0 = total_pops();
    repeat (30) tick();
    chk("full_status_read", (st_cyc[0] >= 0) ? 32'd1 : 32'd0, 32'd1);
    chk("full_not_popped", 32'(mb_pending(0)), 32'd1);
    chk("full_no_pop", 32'(total_pops() - pops0), 32'd0);
    chk("full_no_write", 32'(n_writes()), 32'd16);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("full_after_consume", 32'(ring_count), 32'd14);
    repeat (30) tick();
    chk("wrap_nwr", 32'(n_writes()), 32'd18);
    if (n_writes() == 18) begin
      chk("wrap_addr0", 32'(wr_addr_q[wr_base+16]), 32'h0100);
      chk("wrap_data0", 32'(wr_data_q[wr_base+16]), 32'hBEEF);
      chk("wrap_addr1", 32'(wr_addr_q[wr_base+17]), 32'h0101);
      chk("wrap_data1", 32'(wr_data_q[wr_base+17]), 32'hCAFE);
    end
    chk("wrap_popped", 32'(mb_pending(0)), 32'd0);
    chk("wrap_count", 32'(ring_count), 32'd16);

    // Consume at zero is ignored; consume with a write accept nets to -1.
    do_reset();
    consume = 1'b1;
    tick();
    consume = 1'b0;
    chk("consume_at_zero", 32'(ring_count), 32'd0);
    load(0, 16'h0001, 16'h0002);
    load(1, 16'h0003, 16'h0004);
    enable = 1'b1;
    repeat (30) tick();
    chk("net_pre_count", 32'(ring_count), 32'd4);
    node_mem_waitrequest = 1'b1;
    load(2, 16'h0005, 16'h0006);
    n = 0;
    while (!node_mem_write && n < 60) begin
      tick();
      n++;
    end
    chk("net_write_seen", 32'(node_mem_write), 32'd1);
    consume              = 1'b1;
    node_mem_waitrequest = 1'b0;
    tick();
    consume = 1'b0;
    chk("net_count", 32'(ring_count), 32'd3);
    repeat (15) tick();
    chk("net_final_count", 32'(ring_count), 32'd4);

    // Reset during the second write: nothing popped, message re-forwarded.
    do_reset();
    pops0 = total_pops();
    load(0, 16'h7777, 16'h8888);
    enable = 1'b1;
    n = 0;
    while (!(node_mem_write && node_mem_address == 15'h0101) && n < 60) begin
      tick();
      n++;
    end
    chk("midrst_in_wr2", 32'(node_mem_write), 32'd1);
    reset_reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    tick();
    reset_reset = 1'b0;
    clear_logs();
    chk("midrst_unpopped", 32'(mb_pending(0)), 32'd1);
    chk("midrst_no_pop", 32'(total_pops() - pops0), 32'd0);
    repeat (20) tick();
    chk("midrst_nwr", 32'(n_writes()), 32'd2);
    if (n_writes() == 2) begin
      chk("midrst_addr0", 32'(wr_addr_q[wr_base]), 32'h0100);
      chk("midrst_data0", 32'(wr_data_q[wr_base]), 32'h7777);
      chk("midrst_addr1", 32'(wr_addr_q[wr_base+1]), 32'h0101);
      chk("midrst_data1", 32'(wr_data_q[wr_base+1]), 32'h8888);
    end
    chk("midrst_pops", 32'(total_pops() - pops0), 32'd1);
`ifdef DIRCC_POLLER_STATS_EN
    chk("midrst_msg_count", 32'(msg_count), 32'd1);
`endif

    // Random rounds: random direction subsets, stalls and consumes.
    for (int r = 0; r < 12; r++) begin
      do_reset();
      exp_w.delete();
      mask = 4'($urandom_range(1, 15));
      for (int d = 0; d < 4; d++) begin
        if (mask[d]) begin
          load(d, 16'($urandom), 16'($urandom));
          exp_w.push_back(mb_w0[d]);
          exp_w.push_back(mb_w1[d]);
        end
      end
      enable = 1'b1;
      n = 0;
      while (any_pending() && n < 400) begin
        node_mem_waitrequest = ($urandom_range(0, 2) == 0);
        consume              = ($urandom_range(0, 5) == 0);
        tick();
        n++;
      end
      consume              = 1'b0;
      node_mem_waitrequest = 1'b0;
      repeat (3) tick();
      chk("rand_drained", (n < 400) ? 32'd1 : 32'd0, 32'd1);
      chk("rand_nwr", 32'(n_writes()), 32'(exp_w.size()));
      if (n_writes() == exp_w.size()) begin
        for (int i = 0; i < exp_w.size(); i++) begin
          chk("rand_addr", 32'(wr_addr_q[wr_base+i]), 32'h0100 + i);
          chk("rand_data", 32'(wr_data_q[wr_base+i]), 32'(exp_w[i]));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
